// File: rtl/alp_seq_pkg.sv
// alp_seq_pkg: shared state encoding, ALU opcodes and shift codes for the mul/div sequencer
package alp_seq_pkg;
   typedef enum logic [2:0] {IDLE, CLR, ZCHK, MSTEP, DSHL, DSUB, DONE} state_e;
   localparam logic [3:0] ZERO  = 4'd0;
   localparam logic [3:0] PASSA = 4'd1;
   localparam logic [3:0] PASSB = 4'd2;
   localparam logic [3:0] ADD   = 4'd3;
   localparam logic [3:0] SUB   = 4'd4;
   localparam logic [1:0] SH_NONE  = 2'b00;
   localparam logic [1:0] SH_RIGHT = 2'b01;
   localparam logic [1:0] SH_LEFT  = 2'b10;
endpackage

// File: rtl/alp_mq_reg.sv
// alp_mq_reg: 32-bit MQ register with load, right shift with fill bit, left shift and LSB set
module alp_mq_reg (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        load_i,
   input  logic [31:0] data_i,
   input  logic        shr_i,
   input  logic        shr_in_i,
   input  logic        shl_i,
   input  logic        set_lsb_i,
   input  logic        lsb_i,
   output logic [31:0] q_o
);
   logic [31:0] q_q, q_d;
   always_comb
      q_d = load_i    ? data_i :
            shr_i     ? {shr_in_i, q_q[31:1]} :
            shl_i     ? {q_q[30:0], 1'b0} :
            set_lsb_i ? {q_q[31:1], lsb_i} : q_q;
   always_ff @(posedge clk_i)
      q_q <= rst_i ? '0 : q_d;
   assign q_o = q_q;
endmodule

// File: rtl/alp_muldiv_seq.sv
// alp_muldiv_seq: sequencer for shift-add multiply and restoring divide over a sliced ALU
module alp_muldiv_seq
   import alp_seq_pkg::*;
(
   input  logic        clk_h,
   input  logic        reset_h,
   input  logic        start_h,
   input  logic        op_div_h,
   input  logic [31:0] mq_in_h,
   input  logic        cout_h,
   input  logic        sout_lsb_h,
   input  logic        wmuxz_l,
   output logic [3:0]  alu_op_h,
   output logic [1:0]  shift_h,
   output logic        sin_h,
   output logic        wr_en_h,
   output logic        busy_h,
   output logic        done_h,
   output logic        dvz_h,
   output logic [31:0] mq_h
);
   state_e      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic        dvz_q, dvz_d;
   logic        op_div_q, op_div_d;
   logic        accept, last;
   assign accept = (state_q == IDLE) && start_h;
   assign last   = cnt_q == 5'd31;
   always_ff @(posedge clk_h)
      if (reset_h) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         dvz_q    <= 1'b0;
         op_div_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         dvz_q    <= dvz_d;
         op_div_q <= op_div_d;
      end
   // counter saturates at 31 so the final step never wraps
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      dvz_d    = dvz_q;
      op_div_d = op_div_q;
      case (state_q)
         IDLE:
            if (start_h) begin
               state_d  = CLR;
               cnt_d    = '0;
               dvz_d    = 1'b0;
               op_div_d = op_div_h;
            end
         CLR:  state_d = op_div_q ? ZCHK : MSTEP;
         ZCHK: begin
            state_d = wmuxz_l ? DSHL : DONE;
            dvz_d   = ~wmuxz_l;
         end
         MSTEP: begin
            state_d = last ? DONE : MSTEP;
            cnt_d   = last ? cnt_q : cnt_q + 5'd1;
         end
         DSHL: state_d = DSUB;
         DSUB: begin
            state_d = last ? DONE : DSHL;
            cnt_d   = last ? cnt_q : cnt_q + 5'd1;
         end
         default: state_d = IDLE;
      endcase
   end
   always_comb begin
      alu_op_h = PASSA;
      shift_h  = SH_NONE;
      sin_h    = 1'b0;
      wr_en_h  = 1'b0;
      case (state_q)
         CLR: begin
            alu_op_h = ZERO;
            wr_en_h  = 1'b1;
         end
         ZCHK: alu_op_h = PASSB;
         MSTEP: begin
            alu_op_h = mq_h[0] ? ADD : PASSA;
            shift_h  = SH_RIGHT;
            sin_h    = cout_h & mq_h[0];
            wr_en_h  = 1'b1;
         end
         DSHL: begin
            shift_h = SH_LEFT;
            sin_h   = mq_h[31];
            wr_en_h = 1'b1;
         end
         DSUB: begin
            alu_op_h = SUB;
            wr_en_h  = cout_h;
         end
         default: ;
      endcase
   end
   assign busy_h = state_q != IDLE;
   assign done_h = state_q == DONE;
   assign dvz_h  = dvz_q;
   alp_mq_reg u_mq (
      .clk_i    (clk_h),
      .rst_i    (reset_h),
      .load_i   (accept),
      .data_i   (mq_in_h),
      .shr_i    (state_q == MSTEP),
      .shr_in_i (sout_lsb_h),
      .shl_i    (state_q == DSHL),
      .set_lsb_i(state_q == DSUB),
      .lsb_i    (cout_h),
      .q_o      (mq_h)
   );
endmodule

// File: tb/tb_alp_muldiv_seq.sv
// tb_alp_muldiv_seq: sequencer driven against a behavioural 8-slice ALU and ACC
module tb_alp_muldiv_seq;
   import alp_seq_pkg::*;
   logic        clk_h = 1'b0, reset_h = 1'b1, start_h = 1'b0, op_div_h = 1'b0;
   logic [31:0] mq_in_h = '0;
   logic        cout_h, sout_lsb_h, wmuxz_l;
   logic [3:0]  alu_op_h;
   logic [1:0]  shift_h;
   logic        sin_h, wr_en_h, busy_h, done_h, dvz_h;
   logic [31:0] mq_h;
   logic [31:0] acc_q = '0, b_r = '0;
   logic [32:0] w;
   typedef struct {
      bit          op;
      logic [31:0] a, b, acc, mq;
      bit          dvz;
      int          lat;
   } vec_t;
   vec_t sb[$];
   vec_t tv[10];
   int   total = 0, passed = 0;
   alp_muldiv_seq dut (
      .clk_h(clk_h), .reset_h(reset_h), .start_h(start_h), .op_div_h(op_div_h),
      .mq_in_h(mq_in_h), .cout_h(cout_h), .sout_lsb_h(sout_lsb_h), .wmuxz_l(wmuxz_l),
      .alu_op_h(alu_op_h), .shift_h(shift_h), .sin_h(sin_h), .wr_en_h(wr_en_h),
      .busy_h(busy_h), .done_h(done_h), .dvz_h(dvz_h), .mq_h(mq_h)
   );
   always #5 clk_h = ~clk_h;
   function automatic logic [32:0] slices(input logic [31:0] a, input logic [31:0] b, input logic cin);
      logic c;
      logic [31:0] s;
      logic [4:0] t;
      c = cin;
      s = '0;
      for (int i = 0; i < 8; i++) begin
         t = {1'b0, a[4*i+:4]} + {1'b0, b[4*i+:4]} + {4'b0, c};
         s[4*i+:4] = t[3:0];
         c = t[4];
      end
      return {c, s};
   endfunction
   always_comb begin
      w = {1'b0, acc_q};
      case (alu_op_h)
         ZERO:  w = '0;
         PASSB: w = {1'b0, b_r};
         ADD:   w = slices(acc_q, b_r, 1'b0);
         SUB:   w = slices(acc_q, ~b_r, 1'b1);
         default: ;
      endcase
   end
   assign cout_h     = w[32];
   assign wmuxz_l    = |w[31:0];
   assign sout_lsb_h = w[0];
   always @(posedge clk_h)
      if (wr_en_h)
         acc_q <= shift_h == SH_RIGHT ? {sin_h, w[31:1]} :
                  shift_h == SH_LEFT  ? {w[30:0], sin_h} : w[31:0];
   function automatic vec_t mk(input bit op, input logic [31:0] a, input logic [31:0] b);
      vec_t v;
      logic [63:0] p;
      v.op = op; v.a = a; v.b = b;
      p = {32'b0, a} * {32'b0, b};
      if (!op) begin
         v.acc = p[63:32]; v.mq = p[31:0]; v.dvz = 0; v.lat = 34;
      end else if (b == 0) begin
         v.acc = '0; v.mq = a; v.dvz = 1; v.lat = 3;
      end else begin
         v.acc = a % b; v.mq = a / b; v.dvz = 0; v.lat = 67;
      end
      return v;
   endfunction
   task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", n, act, exp);
   endtask
   task automatic wait_done(output int cyc);
      cyc = 1;
      while (cyc < 200 && !done_h) begin
         @(posedge clk_h); #1;
         cyc++;
      end
   endtask
   task automatic check_out(input string n, input int cyc);
      vec_t e;
      chk({n, "_done_seen"}, 64'(done_h), 64'(1));
      if (sb.size() == 0) begin
         chk({n, "_sb_empty"}, 64'(0), 64'(1));
         return;
      end
      e = sb.pop_front();
      chk({n, "_acc"}, 64'(acc_q), 64'(e.acc));
      chk({n, "_mq"}, 64'(mq_h), 64'(e.mq));
      chk({n, "_dvz"}, 64'(dvz_h), 64'(e.dvz));
      chk({n, "_lat"}, 64'(cyc), 64'(e.lat));
   endtask
   task automatic run_op(input string n, input vec_t v);
      int cyc;
      sb.push_back(v);
      op_div_h = v.op; mq_in_h = v.a; b_r = v.b; start_h = 1'b1;
      @(posedge clk_h); #1;
      start_h = 1'b0;
      wait_done(cyc);
      check_out(n, cyc);
      @(posedge clk_h); #1;
      chk({n, "_done_width"}, 64'(done_h), 64'(0));
   endtask
   task automatic chk_defaults(input string n);
      chk({n, "_busy"}, 64'(busy_h), 64'(0));
      chk({n, "_done"}, 64'(done_h), 64'(0));
      chk({n, "_alu"}, 64'(alu_op_h), 64'(PASSA));
      chk({n, "_shift"}, 64'(shift_h), 64'(SH_NONE));
      chk({n, "_sin"}, 64'(sin_h), 64'(0));
      chk({n, "_wr"}, 64'(wr_en_h), 64'(0));
      chk({n, "_dvz"}, 64'(dvz_h), 64'(0));
      chk({n, "_mq"}, 64'(mq_h), 64'(0));
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      int cyc;
      tv[0] = '{1'b0, 32'd3, 32'd5, 32'd0, 32'hF, 1'b0, 34};
      tv[1] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1, 1'b0, 34};
      tv[2] = '{1'b1, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 67};
      tv[3] = '{1'b1, 32'h1234_5678, 32'd0, 32'd0, 32'h1234_5678, 1'b1, 3};
      tv[4] = mk(1'b0, 32'h1234_5678, 32'h9ABC_DEF0);
      tv[5] = mk(1'b0, 32'd0, 32'hFFFF);
      tv[6] = mk(1'b1, 32'hFFFF_FFFF, 32'h10);
      tv[7] = mk(1'b1, 32'd5, 32'd9);
      tv[8] = mk(1'b0, $urandom, $urandom);
      tv[9] = mk(1'b1, $urandom, $urandom_range(32'h7FFF_FFFF, 1));
      repeat (3) @(posedge clk_h);
      #1;
      chk_defaults("reset");
      reset_h = 1'b0;
      @(posedge clk_h); #1;
      for (int i = 0; i < 10; i++) run_op($sformatf("vec%0d", i), tv[i]);
      // divide-by-zero flag must persist in IDLE until the next start
      run_op("dvz", mk(1'b1, 32'h55, 32'd0));
      repeat (3) @(posedge clk_h);
      #1;
      chk("dvz_hold", 64'(dvz_h), 64'(1));
      run_op("dvz_clear", mk(1'b0, 32'd6, 32'd7));
      // mid-operation start is ignored, then reset together with start
      op_div_h = 1'b0; mq_in_h = 32'h0000_FFFF; b_r = 32'd3; start_h = 1'b1;
      @(posedge clk_h); #1;
      start_h = 1'b0;
      repeat (6) @(posedge clk_h);
      #1;
      op_div_h = 1'b1; mq_in_h = 32'hAAAA_AAAA; start_h = 1'b1;
      @(posedge clk_h); #1;
      start_h = 1'b0;
      chk("busy_ignore_shift", 64'(shift_h), 64'(SH_RIGHT));
      chk("busy_ignore_busy", 64'(busy_h), 64'(1));
      repeat (4) @(posedge clk_h);
      #1;
      chk("step10_shift", 64'(shift_h), 64'(SH_RIGHT));
      reset_h = 1'b1; start_h = 1'b1;
      @(posedge clk_h); #1;
      reset_h = 1'b0; start_h = 1'b0;
      chk_defaults("midrst");
      @(posedge clk_h); #1;
      chk("midrst_start_dropped", 64'(busy_h), 64'(0));
      // back-to-back with start held high
      sb.push_back(mk(1'b0, 32'd7, 32'd9));
      op_div_h = 1'b0; mq_in_h = 32'd7; b_r = 32'd9; start_h = 1'b1;
      @(posedge clk_h); #1;
      wait_done(cyc);
      check_out("b2b_first", cyc);
      @(posedge clk_h); #1;
      chk("b2b_done_width", 64'(done_h), 64'(0));
      chk("b2b_idle_gap", 64'(busy_h), 64'(0));
      sb.push_back(mk(1'b1, 32'd1000, 32'd33));
      op_div_h = 1'b1; mq_in_h = 32'd1000; b_r = 32'd33;
      @(posedge clk_h); #1;
      start_h = 1'b0;
      chk("b2b_second_busy", 64'(busy_h), 64'(1));
      wait_done(cyc);
      check_out("b2b_second", cyc);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
